i2s_tx_ctrl: RTL and testbench

Transmit-side sequencer for the I2S port, driven by the `sclk`/`lrclk` pair from the I2S clock generator in the same `clk` domain. Accepts one stereo sample per frame over a valid/ready stream and shifts it MSB-first onto `sd` with standard I2S one-bit delay. Inserts silence and counts underruns when no sample is available. Sits between the audio DSP output stream and the codec pins.

---
 rtl/i2s_pkg.sv | 9 +
 rtl/i2s_tx_ctrl_if.sv | 11 +
 rtl/i2s_edge_det.sv | 26 ++
 rtl/i2s_tx_ctrl.sv | 139 +++++++++++++
 tb/tb_i2s_tx_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: transmit sequencer states and channel encoding of lrclk.
package i2s_pkg;

   typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} i2s_tx_state_t;

   localparam logic LEFT_CH  = 1'b0;
   localparam logic RIGHT_CH = 1'b1;

endpackage

// File: rtl/i2s_tx_ctrl_if.sv
// Stereo sample stream into the I2S transmitter: {left, right} with valid/ready.
interface i2s_tx_ctrl_if #(
   parameter int DW = 24
);
   logic [2*DW-1:0] tdata;
   logic            tvalid;
   logic            tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/i2s_edge_det.sv
// Registers one clk-domain level and flags its rising and falling edges.
module i2s_edge_det #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic q_r;

   // previous-cycle copy of the input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= RST_VAL;
      end else begin
         q_r <= d;
      end
   end

   assign rise = ~q_r & d;
   assign fall = q_r & ~d;

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit sequencer: accepts one stereo sample per frame and shifts it
// MSB-first onto sd with the one-bit I2S delay; inserts silence on underrun.
module i2s_tx_ctrl
   import i2s_pkg::*;
#(
   parameter int DW   = 24,
   parameter int UR_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            sclk,
   input  logic            lrclk,
   i2s_tx_ctrl_if.slave    s,
   output logic            sd,
   output logic            busy,
   output logic            underrun,
   output logic [UR_W-1:0] underrun_cnt
);

   localparam int CW = $clog2(DW + 1);

   i2s_tx_state_t   state_r, state_nxt_s;
   logic            sfall_s, unused_srise_s, lfall_s, lrise_s;
   logic            ready_s, xfer_s, starve_s, load_l_s, load_r_s;
   logic [2*DW-1:0] hold_r, hold_nxt_s;
   logic [DW-1:0]   shreg_r;
   logic [CW-1:0]   bcnt_r;
   logic            sd_r, busy_r, underrun_r;
   logic [UR_W-1:0] ur_cnt_r;

   // sclk idles low out of reset, lrclk idles high so the first real left edge is a fall
   i2s_edge_det #(.RST_VAL(1'b0)) u_sclk_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sclk),
      .rise  (unused_srise_s),
      .fall  (sfall_s)
   );

   i2s_edge_det #(.RST_VAL(1'b1)) u_lrclk_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (lrclk),
      .rise  (lrise_s),
      .fall  (lfall_s)
   );

   // frame sequencing: a started frame always finishes its right channel
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (en) state_nxt_s = SYNC;
            else    state_nxt_s = IDLE;
         end
         SYNC: begin
            if (lfall_s) state_nxt_s = LEFT;
            else         state_nxt_s = SYNC;
         end
         LEFT: begin
            if (lrise_s) state_nxt_s = RIGHT;
            else         state_nxt_s = LEFT;
         end
         RIGHT: begin
            if (lfall_s) state_nxt_s = en ? LEFT : IDLE;
            else         state_nxt_s = RIGHT;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // sample acceptance and the word each channel load picks up
   always_comb begin
      ready_s  = lfall_s & en & ((state_r == SYNC) | (state_r == RIGHT));
      xfer_s   = ready_s & s.tvalid;
      starve_s = ready_s & ~s.tvalid;
      if (xfer_s) begin
         hold_nxt_s = s.tdata;
      end else if (starve_s) begin
         hold_nxt_s = '0;
      end else begin
         hold_nxt_s = hold_r;
      end
      load_l_s = (state_nxt_s == LEFT) & ((state_r == SYNC) | (state_r == RIGHT));
      load_r_s = (state_r == LEFT) & lrise_s;
   end

   // state, hold register and status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         hold_r     <= '0;
         busy_r     <= 1'b0;
         underrun_r <= 1'b0;
         ur_cnt_r   <= '0;
      end else begin
         state_r    <= state_nxt_s;
         hold_r     <= hold_nxt_s;
         busy_r     <= (state_nxt_s == LEFT) | (state_nxt_s == RIGHT);
         underrun_r <= starve_s;
         if (starve_s && (ur_cnt_r != {UR_W{1'b1}})) begin
            ur_cnt_r <= ur_cnt_r + {{(UR_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // serializer: a channel edge only loads, so its MSB goes out on the following sclk fall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_r <= '0;
         bcnt_r  <= '0;
         sd_r    <= 1'b0;
      end else if (load_l_s) begin
         shreg_r <= hold_nxt_s[2*DW-1:DW];
         bcnt_r  <= '0;
      end else if (load_r_s) begin
         shreg_r <= hold_r[DW-1:0];
         bcnt_r  <= '0;
      end else if (!busy_r) begin
         sd_r <= 1'b0;
      end else if (sfall_s) begin
         if (bcnt_r < CW'(DW)) begin
            sd_r    <= shreg_r[DW-1];
            shreg_r <= {shreg_r[DW-2:0], 1'b0};
            bcnt_r  <= bcnt_r + CW'(1);
         end else begin
            sd_r <= 1'b0;
         end
      end
   end

   assign s.tready     = ready_s;
   assign sd           = sd_r;
   assign busy         = busy_r;
   assign underrun     = underrun_r;
   assign underrun_cnt = ur_cnt_r;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl: FS_RATIO=256 clock pattern (sclk = 4 clk, lrclk half = 128 clk).
module tb_i2s_tx_ctrl;

   localparam int DW   = 24;
   localparam int UR_W = 4;
   localparam logic [47:0] P1 = {24'hA5A5A5, 24'h5A5A5A};
   localparam logic [47:0] P2 = {24'h123456, 24'hFEDCBA};

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic [7:0]      cg = 8'd0;
   logic            sclk, lrclk;
   logic            sd, busy, underrun;
   logic [UR_W-1:0] underrun_cnt;

   int total = 0;
   int bad   = 0;
   int tready_cnt = 0, ur_pulses = 0, xfer_cnt = 0, sd_ones = 0;
   int snap, snap2;
   logic [63:0] fr;

   i2s_tx_ctrl_if #(.DW(DW)) s_if ();

   i2s_tx_ctrl #(.DW(DW), .UR_W(UR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .sclk         (sclk),
      .lrclk        (lrclk),
      .s            (s_if),
      .sd           (sd),
      .busy         (busy),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clk = ~clk;

   // clock generator model: sclk falls together with every lrclk toggle
   always @(posedge clk) cg <= cg + 8'd1;
   assign sclk  = cg[1];
   assign lrclk = cg[7];

   // event counters sampled once per cycle
   always @(posedge clk) begin
      if (s_if.tready)                tready_cnt <= tready_cnt + 1;
      if (s_if.tready && s_if.tvalid) xfer_cnt   <= xfer_cnt + 1;
      if (underrun)                   ur_pulses  <= ur_pulses + 1;
      if (sd)                         sd_ones    <= sd_ones + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic wait_cg(input logic [7:0] v);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cg != v && n < 300);
      if (cg != v) begin
         total++;
         bad++;
         $error("FAIL wait_cg observed=%0d expected=%0d", cg, v);
      end
   endtask

   // call at the negedge where cg==0; samples sd at every sclk rise of the frame
   task automatic capture_frame(output logic [63:0] f);
      repeat (2) @(negedge clk);
      for (int j = 0; j < 64; j++) begin
         f[63-j] = sd;
         if (j < 63) repeat (4) @(negedge clk);
      end
   endtask

   function automatic logic [63:0] exp_frame(input logic [47:0] p);
      return {1'b0, p[47:24], 7'b0, 1'b0, p[23:0], 7'b0};
   endfunction

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata = '0;
      repeat (3) @(negedge clk);
      check("rst_sd", sd, 0);
      check("rst_tready", s_if.tready, 0);
      check("rst_busy", busy, 0);
      check("rst_underrun", underrun, 0);
      check("rst_cnt", underrun_cnt, 0);

      // streaming with valid held high
      rst_n = 1'b1;
      en = 1'b1;
      s_if.tvalid = 1'b1;
      s_if.tdata = P1;
      wait_cg(8'd0);
      check("f1_tready", s_if.tready, 1);
      check("f1_busy_sync", busy, 0);
      snap = tready_cnt;
      capture_frame(fr);
      check("f1_data", fr, exp_frame(P1));
      check("f1_busy", busy, 1);
      s_if.tdata = P2;
      wait_cg(8'd0);
      check("f2_tready", s_if.tready, 1);
      capture_frame(fr);
      check("f2_data", fr, exp_frame(P2));
      check("tready_rate", tready_cnt - snap, 2);

      // underrun frame
      s_if.tvalid = 1'b0;
      wait_cg(8'd0);
      check("ur_tready", s_if.tready, 1);
      snap = ur_pulses;
      snap2 = xfer_cnt;
      capture_frame(fr);
      check("ur_data", fr, 64'd0);
      check("ur_cnt", underrun_cnt, 1);
      check("ur_pulses", ur_pulses - snap, 1);
      check("ur_no_xfer", xfer_cnt - snap2, 0);

      // en dropped 10 clk into LEFT: frame completes, then IDLE
      s_if.tvalid = 1'b1;
      s_if.tdata = P2;
      wait_cg(8'd0);
      fork
         capture_frame(fr);
         begin
            wait_cg(8'd10);
            en = 1'b0;
         end
      join
      check("en_off_data", fr, exp_frame(P2));
      wait_cg(8'd0);
      check("en_off_tready", s_if.tready, 0);
      wait_cg(8'd3);
      check("en_off_busy", busy, 0);
      check("en_off_sd", sd, 0);
      snap = tready_cnt;
      wait_cg(8'd0);
      wait_cg(8'd40);
      check("idle_no_tready", tready_cnt - snap, 0);
      check("idle_sd", sd, 0);

      // en raised mid-left: wait for a full lrclk rise then fall
      en = 1'b1;
      s_if.tdata = P1;
      snap = tready_cnt;
      wait_cg(8'd255);
      check("mid_no_tready", tready_cnt - snap, 0);
      wait_cg(8'd0);
      check("mid_tready", s_if.tready, 1);
      capture_frame(fr);
      check("mid_data", fr, exp_frame(P1));

      // reset during bit 12 of the left word (0x123456 -> that bit is 1)
      s_if.tdata = P2;
      wait_cg(8'd0);
      wait_cg(8'd50);
      check("pre_rst_sd", sd, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sd", sd, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cnt", underrun_cnt, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      snap = sd_ones;
      wait_cg(8'd0);
      check("post_rst_quiet", sd_ones - snap, 0);
      check("post_rst_tready", s_if.tready, 1);
      capture_frame(fr);
      check("post_rst_data", fr, exp_frame(P2));

      // 20 starved frames with a 4-bit counter
      s_if.tvalid = 1'b0;
      snap = ur_pulses;
      for (int i = 0; i < 20; i++) begin
         wait_cg(8'd0);
         wait_cg(8'd1);
         if (i == 13) check("sat_cnt14", underrun_cnt, 14);
      end
      wait_cg(8'd5);
      check("sat_pulses", ur_pulses - snap, 20);
      check("sat_cnt", underrun_cnt, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
